// File: rtl/counter_updn_mod.sv
// Up/down modulo-MOD counter with enable, synchronous load, wrap/saturate mode and sticky overflow.
// Optional capture register enabled by defining COUNTER_CAPTURE_EN; otherwise q_cap is tied to zero.
module counter_updn_mod #(
    parameter int W   = 10,
    parameter int MOD = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    input  logic         up,
    input  logic         sat,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         clr_ovf,
    input  logic         cap,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         wrap,
    output logic         ovf,
    output logic [W-1:0] q_cap
);

    generate
        if (MOD < 2 || MOD > (2 ** W)) begin : g_bad_mod
            $error("counter_updn_mod: MOD must satisfy 2 <= MOD <= 2**W");
        end
    endgenerate

    // One extra bit so MOD == 2**W still compares correctly against d.
    localparam logic [W:0]   MODW = (W+1)'(MOD);
    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    logic         bnd;
    logic [W-1:0] dclamp;

    always_comb begin
        bnd    = up ? (q == MAXV) : (q == '0);
        tc     = enb & bnd & ~ld & ~rst;
        dclamp = ({1'b0, d} < MODW) ? d : MAXV;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (ld) begin
                q <= dclamp;
            end else if (enb) begin
                if (!bnd) begin
                    q <= up ? q + 1'b1 : q - 1'b1;
                end else if (!sat) begin
                    q    <= up ? '0 : MAXV;
                    wrap <= 1'b1;
                end
            end
            // A fresh boundary hit beats a simultaneous clear.
            if (tc) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef COUNTER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            q_cap <= '0;
        end else if (cap) begin
            q_cap <= q;
        end
    end
`else
    logic unused_cap;
    assign unused_cap = cap;
    assign q_cap      = '0;
`endif

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed self-checking bench for counter_updn_mod (W=10, MOD=1000) plus a MOD=10 cascade pair.
module tb_counter_updn_mod;

    logic       clk = 1'b0;
    logic       rst, enb, up, sat, ld, clr_ovf, cap;
    logic [9:0] d;
    logic [9:0] q, q_cap;
    logic       tc, wrap, ovf;

    logic       cenb;
    logic [3:0] q0, q1, qc0, qc1;
    logic       tc0, tc1, w0, w1, o0, o1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_updn_mod #(.W(10), .MOD(1000)) dut (
        .clk(clk), .rst(rst), .enb(enb), .up(up), .sat(sat), .ld(ld), .d(d),
        .clr_ovf(clr_ovf), .cap(cap), .q(q), .tc(tc), .wrap(wrap), .ovf(ovf), .q_cap(q_cap)
    );

    counter_updn_mod #(.W(4), .MOD(10)) c0 (
        .clk(clk), .rst(rst), .enb(cenb), .up(1'b1), .sat(1'b0), .ld(1'b0), .d(4'd0),
        .clr_ovf(1'b0), .cap(1'b0), .q(q0), .tc(tc0), .wrap(w0), .ovf(o0), .q_cap(qc0)
    );

    counter_updn_mod #(.W(4), .MOD(10)) c1 (
        .clk(clk), .rst(rst), .enb(tc0), .up(1'b1), .sat(1'b0), .ld(1'b0), .d(4'd0),
        .clr_ovf(1'b0), .cap(1'b0), .q(q1), .tc(tc1), .wrap(w1), .ovf(o1), .q_cap(qc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; enb = 1; ld = 1; d = 10'd5; up = 1; sat = 0; clr_ovf = 0; cap = 1; cenb = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (q !== 10'd0) begin errors++; $display("[TB] FAIL reset_q got %0d exp 0", q); end
            checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got %b exp 0", wrap); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b exp 0", ovf); end
            checks++; if (q_cap !== 10'd0) begin errors++; $display("[TB] FAIL reset_qcap got %0d exp 0", q_cap); end
            checks++; if (tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc got %b exp 0", tc); end
        end
        checks++; if (q0 !== 4'd0 || q1 !== 4'd0) begin errors++; $display("[TB] FAIL reset_cascade got %0d/%0d exp 0/0", q1, q0); end
        rst = 0; cap = 0; ld = 0; enb = 0;
    endtask

    task automatic test_wrap_up();
        logic [9:0] expq [4] = '{10'd998, 10'd999, 10'd0, 10'd1};
        logic       exptc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       expw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       expo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        ld = 1; d = 10'd997; enb = 0;
        tick();
        checks++; if (q !== 10'd997) begin errors++; $display("[TB] FAIL load_997 got %0d exp 997", q); end
        ld = 0; up = 1; sat = 0; enb = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (tc !== exptc[i]) begin errors++; $display("[TB] FAIL wrapup_tc[%0d] got %b exp %b", i, tc, exptc[i]); end
            tick();
            checks++; if (q !== expq[i]) begin errors++; $display("[TB] FAIL wrapup_q[%0d] got %0d exp %0d", i, q, expq[i]); end
            checks++; if (wrap !== expw[i]) begin errors++; $display("[TB] FAIL wrapup_wrap[%0d] got %b exp %b", i, wrap, expw[i]); end
            checks++; if (ovf !== expo[i]) begin errors++; $display("[TB] FAIL wrapup_ovf[%0d] got %b exp %b", i, ovf, expo[i]); end
        end
        enb = 0;
    endtask

    task automatic test_sat_down();
        logic expo[3] = '{1'b0, 1'b1, 1'b1};
        ld = 1; d = 10'd1; clr_ovf = 1;
        tick();
        checks++; if (q !== 10'd1) begin errors++; $display("[TB] FAIL satdn_load got %0d exp 1", q); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL satdn_clr_on_load got %b exp 0", ovf); end
        ld = 0; clr_ovf = 0; up = 0; sat = 1; enb = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== 10'd0) begin errors++; $display("[TB] FAIL satdn_q[%0d] got %0d exp 0", i, q); end
            checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL satdn_wrap[%0d] got %b exp 0", i, wrap); end
            checks++; if (ovf !== expo[i]) begin errors++; $display("[TB] FAIL satdn_ovf[%0d] got %b exp %b", i, ovf, expo[i]); end
        end
        enb = 0; clr_ovf = 1;
        tick();
        clr_ovf = 0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL satdn_clr got %b exp 0", ovf); end
        checks++; if (q !== 10'd0) begin errors++; $display("[TB] FAIL hold_q got %0d exp 0", q); end
    endtask

    task automatic test_load_clamp();
        logic [9:0] din [4] = '{10'd1023, 10'd1000, 10'd999, 10'd3};
        logic [9:0] dexp[4] = '{10'd999, 10'd999, 10'd999, 10'd3};
        ld = 1; enb = 1; up = 1; sat = 0;
        for (int i = 0; i < 4; i++) begin
            d = din[i];
            #1;
            checks++; if (tc !== 1'b0) begin errors++; $display("[TB] FAIL clamp_tc[%0d] got %b exp 0", i, tc); end
            tick();
            checks++; if (q !== dexp[i]) begin errors++; $display("[TB] FAIL clamp_q[%0d] got %0d exp %0d", i, q, dexp[i]); end
            checks++; if (wrap !== 1'b0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL clamp_flags[%0d] got %b%b exp 00", i, wrap, ovf); end
        end
        d = 10'd999;
        tick();
        ld = 0; enb = 0;
    endtask

    task automatic test_set_wins();
        up = 1; sat = 0; enb = 1; clr_ovf = 1;
        tick();
        clr_ovf = 0; enb = 0;
        checks++; if (q !== 10'd0) begin errors++; $display("[TB] FAIL setwins_q got %0d exp 0", q); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL setwins_ovf got %b exp 1", ovf); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("[TB] FAIL setwins_wrap got %b exp 1", wrap); end
        up = 0; enb = 1;
        tick();
        enb = 0;
        checks++; if (q !== 10'd999) begin errors++; $display("[TB] FAIL downwrap_q got %0d exp 999", q); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("[TB] FAIL downwrap_wrap got %b exp 1", wrap); end
        tick();
        checks++; if (wrap !== 1'b0 || q !== 10'd999) begin errors++; $display("[TB] FAIL downwrap_hold got %b/%0d exp 0/999", wrap, q); end
    endtask

    task automatic test_cascade();
        cenb = 1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (q1 !== 4'd1 || q0 !== 4'd0) begin errors++; $display("[TB] FAIL cascade10 got %0d/%0d exp 1/0", q1, q0); end
        for (int i = 0; i < 15; i++) tick();
        cenb = 0;
        checks++; if (q1 !== 4'd2 || q0 !== 4'd5) begin errors++; $display("[TB] FAIL cascade25 got %0d/%0d exp 2/5", q1, q0); end
    endtask

    task automatic test_capture();
        logic [9:0] expcap;
`ifdef COUNTER_CAPTURE_EN
        expcap = 10'd42;
`else
        expcap = 10'd0;
`endif
        ld = 1; d = 10'd42;
        tick();
        ld = 0; enb = 1; up = 1; cap = 1;
        tick();
        checks++; if (q !== 10'd43) begin errors++; $display("[TB] FAIL cap_q got %0d exp 43", q); end
        checks++; if (q_cap !== expcap) begin errors++; $display("[TB] FAIL cap_val got %0d exp %0d", q_cap, expcap); end
        cap = 0;
        tick();
        enb = 0;
        checks++; if (q !== 10'd44 || q_cap !== expcap) begin errors++; $display("[TB] FAIL cap_hold got %0d/%0d exp 44/%0d", q, q_cap, expcap); end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_set_wins();
        test_cascade();
        test_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
